// File: rtl/array_mem_pkg.sv
// Shared defaults and Array bus field layout for the word memory and its clients.
package array_mem_pkg;

  localparam int ADDR_N_DEF = 8;
  localparam int INT_N_DEF  = 8;

  // Request fields as a client would bundle them (default widths).
  typedef struct packed {
    logic [ADDR_N_DEF-1:0] addr;
    logic                  we;
    logic [INT_N_DEF-1:0]  di;
  } arr_req_t;

  // Response fields returned one cycle after an accepted read.
  typedef struct packed {
    logic                 rvalid;
    logic [INT_N_DEF-1:0] dout;
  } arr_rsp_t;

endpackage

// File: rtl/array_mem_if.sv
// Array bus: valid/ready request with address, write enable and data; registered read data.
interface array_mem_if
  import array_mem_pkg::*;
#(
  parameter int ADDR_N = ADDR_N_DEF,
  parameter int INT_N  = INT_N_DEF
);
  logic              arr_valid;
  logic              arr_ready;
  logic [ADDR_N-1:0] arr_addr;
  logic              arr_we;
  logic [INT_N-1:0]  arr_di;
  logic [INT_N-1:0]  arr_do;
  logic              arr_rvalid;

  modport master (
    output arr_valid, arr_addr, arr_we, arr_di,
    input  arr_ready, arr_do, arr_rvalid
  );

  modport slave (
    input  arr_valid, arr_addr, arr_we, arr_di,
    output arr_ready, arr_do, arr_rvalid
  );
endinterface

// File: rtl/array_mem_core.sv
// Bare single-port RAM: preloaded word i = i, write port and registered read port.
module array_mem_core
  import array_mem_pkg::*;
#(
  parameter int ADDR_N = ADDR_N_DEF,
  parameter int INT_N  = INT_N_DEF
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_N-1:0] i_addr,
  input  logic [INT_N-1:0]  i_di,
  output logic [INT_N-1:0]  o_do
);
  localparam int DEPTH = 1 << ADDR_N;

  typedef logic [DEPTH-1:0][INT_N-1:0] mem_t;

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = INT_N'(i);
    return m;
  endfunction

  // Power-up image only; reset never touches the array.
  mem_t             r_mem = init_mem();
  logic [INT_N-1:0] r_do;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_di;
  end

  always_ff @(posedge clk) begin
    if (i_rst)     r_do <= '0;
    else if (i_re) r_do <= r_mem[i_addr];
  end

  assign o_do = r_do;
endmodule

// File: rtl/array_mem.sv
// Array bus slave: handshake, ready and read-valid generation around the RAM core.
module array_mem
  import array_mem_pkg::*;
#(
  parameter int ADDR_N = ADDR_N_DEF,
  parameter int INT_N  = INT_N_DEF
) (
  input  logic       clk,
  input  logic       rst,
  array_mem_if.slave arr
);
  logic r_ready;
  logic r_rvalid;
  logic w_ready;
  logic w_acc;
  logic w_rd;
  logic w_wr;

  // Gate with rst so a request in the first reset cycle is ignored too.
  assign w_ready = r_ready & ~rst;
  assign w_acc   = arr.arr_valid & w_ready;
  assign w_rd    = w_acc & ~arr.arr_we;
  assign w_wr    = w_acc &  arr.arr_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready  <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      r_ready  <= 1'b1;
      r_rvalid <= w_rd;
    end
  end

  array_mem_core #(
    .ADDR_N (ADDR_N),
    .INT_N  (INT_N)
  ) u_core (
    .clk    (clk),
    .i_rst  (rst),
    .i_we   (w_wr),
    .i_re   (w_rd),
    .i_addr (arr.arr_addr),
    .i_di   (arr.arr_di),
    .o_do   (arr.arr_do)
  );

  assign arr.arr_ready  = w_ready;
  assign arr.arr_rvalid = r_rvalid;
endmodule

// File: tb/tb_array_mem.sv
// Directed vector bench for array_mem: table of single-cycle steps plus a reset-mid-operation sequence.
module tb_array_mem;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  array_mem_if #(.ADDR_N(8), .INT_N(8)) arr_if ();

  array_mem #(.ADDR_N(8), .INT_N(8)) dut (
    .clk (clk),
    .rst (rst),
    .arr (arr_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic       we;
    logic [7:0] addr;
    logic [7:0] di;
    logic       ready;   // expected before the edge
    logic       rvalid;  // expected after the edge
    logic [7:0] dout;    // expected after the edge
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, v, w, input logic [7:0] a, d,
                     input logic er, erv, input logic [7:0] edo, input string nm);
    vec_t t;
    t.rst = r; t.vld = v; t.we = w; t.addr = a; t.di = d;
    t.ready = er; t.rvalid = erv; t.dout = edo; t.name = nm;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle at negedge, check ready before the edge, rvalid/do after it.
  task automatic step(input vec_t t);
    @(negedge clk);
    rst              = t.rst;
    arr_if.arr_valid = t.vld;
    arr_if.arr_we    = t.we;
    arr_if.arr_addr  = t.addr;
    arr_if.arr_di    = t.di;
    #1;
    chk({t.name, ".ready"}, 32'(arr_if.arr_ready), 32'(t.ready));
    @(posedge clk);
    #1;
    chk({t.name, ".rvalid"}, 32'(arr_if.arr_rvalid), 32'(t.rvalid));
    chk({t.name, ".do"}, 32'(arr_if.arr_do), 32'(t.dout));
  endtask

  initial begin
    arr_if.arr_valid = 1'b0;
    arr_if.arr_we    = 1'b0;
    arr_if.arr_addr  = '0;
    arr_if.arr_di    = '0;

    //   rst   vld   we    addr   di     rdy   rv    do
    add(1'b1, 1'b0, 1'b0, 8'd0,  8'h00, 1'b0, 1'b0, 8'd0,  "rst0");
    add(1'b1, 1'b1, 1'b0, 8'd9,  8'h00, 1'b0, 1'b0, 8'd0,  "rst1_rd");
    add(1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 1'b0, 1'b0, 8'd0,  "release");
    add(1'b0, 1'b1, 1'b0, 8'd1,  8'h00, 1'b1, 1'b1, 8'd1,  "rd1");
    add(1'b0, 1'b1, 1'b0, 8'd2,  8'h00, 1'b1, 1'b1, 8'd2,  "rd2");
    add(1'b0, 1'b1, 1'b0, 8'd3,  8'h00, 1'b1, 1'b1, 8'd3,  "rd3");
    add(1'b0, 1'b1, 1'b1, 8'd5,  8'hAA, 1'b1, 1'b0, 8'd3,  "wr5");
    add(1'b0, 1'b1, 1'b0, 8'd5,  8'h00, 1'b1, 1'b1, 8'hAA, "rd5");
    add(1'b0, 1'b1, 1'b0, 8'd255,8'h00, 1'b1, 1'b1, 8'd255,"rd255");
    add(1'b0, 1'b1, 1'b0, 8'd0,  8'h00, 1'b1, 1'b1, 8'd0,  "rd0");
    add(1'b0, 1'b1, 1'b0, 8'd4,  8'h00, 1'b1, 1'b1, 8'd4,  "rd4");
    add(1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 1'b1, 1'b0, 8'd4,  "idle1");
    add(1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 1'b1, 1'b0, 8'd4,  "idle2");
    add(1'b0, 1'b0, 1'b0, 8'd0,  8'h00, 1'b1, 1'b0, 8'd4,  "idle3");
    add(1'b0, 1'b0, 1'b1, 8'd10, 8'hFF, 1'b1, 1'b0, 8'd4,  "nvld_wr10");
    add(1'b0, 1'b1, 1'b0, 8'd10, 8'h00, 1'b1, 1'b1, 8'd10, "rd10");
    add(1'b0, 1'b1, 1'b1, 8'd9,  8'h5C, 1'b1, 1'b0, 8'd10, "wr9");
    add(1'b0, 1'b1, 1'b0, 8'd9,  8'h00, 1'b1, 1'b1, 8'h5C, "rd9");
    add(1'b0, 1'b1, 1'b1, 8'd255,8'h81, 1'b1, 1'b0, 8'h5C, "wr255");
    add(1'b0, 1'b1, 1'b0, 8'd255,8'h00, 1'b1, 1'b1, 8'h81, "rd255b");

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Reset lands right after an accepted read; the write issued during reset is dropped.
    begin
      vec_t s;
      s.di = 8'h00;
      s.rst = 1'b0; s.vld = 1'b1; s.we = 1'b0; s.addr = 8'd6;
      s.ready = 1'b1; s.rvalid = 1'b1; s.dout = 8'd6; s.name = "mid_rd6";
      step(s);
      s.rst = 1'b1; s.vld = 1'b1; s.we = 1'b1; s.addr = 8'd7; s.di = 8'h33;
      s.ready = 1'b0; s.rvalid = 1'b0; s.dout = 8'd0; s.name = "mid_rst_wr7";
      step(s);
      s.rst = 1'b0; s.vld = 1'b1; s.we = 1'b0; s.addr = 8'd7; s.di = 8'h00;
      s.ready = 1'b0; s.rvalid = 1'b0; s.dout = 8'd0; s.name = "mid_release";
      step(s);
      s.ready = 1'b1; s.rvalid = 1'b1; s.dout = 8'd7; s.name = "mid_rd7";
      step(s);
      s.vld = 1'b0;
      s.ready = 1'b1; s.rvalid = 1'b0; s.dout = 8'd7; s.name = "mid_idle";
      step(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
